// File: rtl/hmul_sequencer.sv
// Sequences one multiplier datapath through clear, load A, accumulate B, drain.
// Optional 16-bit busy-cycle counter on perf_cycles when HMUL_SEQ_PERF_EN is defined.

// Multiplier datapath: holds A, accumulates A*B, and presents row-1 onward.
module hmul_seq_datapath #(
   parameter int DIMENSION        = 1,
   parameter int DIM_WIDTH        = 1,
   parameter int CIPHERTEXT_WIDTH = 10,
   parameter int PARALLEL         = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [DIM_WIDTH:0]                   row,
   input  logic                                 ciphertext_select,
   input  logic                                 en,
   input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] op,
   output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] result_partial
);
   localparam int W      = CIPHERTEXT_WIDTH;
   localparam int NUM_A  = DIMENSION + 1;
   localparam int NUM_P  = 2 * DIMENSION + 1;

   logic [NUM_A*W-1:0] a_q, a_d;
   logic [NUM_P*W-1:0] acc_q, acc_d;

   always_comb begin
      a_d   = a_q;
      acc_d = acc_q;
      if (!rst_n) begin
         a_d   = '0;
         acc_d = '0;
      end else if (en) begin
         for (int p = 0; p < PARALLEL; p++) begin
            if (!ciphertext_select) begin
               if (int'(row) + p < NUM_A)
                  a_d[(int'(row) + p)*W +: W] = op[p*W +: W];
            end else begin
               // B coefficient at index row+p contributes to every product index row+p+j.
               for (int j = 0; j < NUM_A; j++) begin
                  if (int'(row) + p + j < NUM_P)
                     acc_d[(int'(row) + p + j)*W +: W] =
                        acc_d[(int'(row) + p + j)*W +: W] + a_q[j*W +: W] * op[p*W +: W];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      a_q   <= a_d;
      acc_q <= acc_d;
   end

   always_comb begin
      result_partial = '0;
      for (int p = 0; p < PARALLEL; p++) begin
         if ((int'(row) - 1 + p >= 0) && (int'(row) - 1 + p < NUM_P))
            result_partial[p*W +: W] = acc_q[(int'(row) - 1 + p)*W +: W];
      end
   end
endmodule

module hmul_sequencer #(
   parameter int DIMENSION        = 1,
   parameter int DIM_WIDTH        = 1,
   parameter int CIPHERTEXT_WIDTH = 10,
   parameter int PARALLEL         = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   output logic                                 busy,
   output logic                                 done,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] out_data,
   output logic [DIM_WIDTH:0]                   out_index,
   output logic                                 mult_rst_n,
   output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] mult_op,
   output logic [DIM_WIDTH:0]                   mult_row,
   output logic                                 mult_sel,
   output logic                                 mult_en,
   output logic [2:0]                           state_dbg
`ifdef HMUL_SEQ_PERF_EN
   ,
   output logic [15:0]                          perf_cycles
`endif
);
   localparam int IW    = DIM_WIDTH + 1;
   localparam int NUM_A = DIMENSION + 1;
   localparam int NUM_P = 2 * DIMENSION + 1;

   // Both streams use valid/ready: a beat transfers on a rising edge where valid and ready are both high.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LOAD_A = 3'd2,
      S_LOAD_B = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               idx_d   = '0;
            end
         end
         S_CLEAR: begin
            state_d = S_LOAD_A;
            idx_d   = '0;
         end
         S_LOAD_A: begin
            if (in_valid) begin
               if (int'(idx_q) + PARALLEL >= NUM_A) begin
                  state_d = S_LOAD_B;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(PARALLEL);
               end
            end
         end
         S_LOAD_B: begin
            if (in_valid) begin
               if (int'(idx_q) + PARALLEL >= NUM_A) begin
                  state_d = S_DRAIN;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(PARALLEL);
               end
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (int'(idx_q) + PARALLEL >= NUM_P) state_d = S_DONE;
               else                                 idx_d   = idx_q + IW'(PARALLEL);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_index = '0;
      mult_row  = '0;
      mult_sel  = 1'b0;
      mult_en   = 1'b0;
      case (state_q)
         S_LOAD_A: begin
            in_ready = 1'b1;
            mult_row = idx_q;
            mult_en  = in_valid;
         end
         S_LOAD_B: begin
            in_ready = 1'b1;
            mult_row = idx_q;
            mult_sel = 1'b1;
            mult_en  = in_valid;
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            out_index = idx_q;
            // The multiplier presents index row-1, so point one past k.
            mult_row  = idx_q + IW'(1);
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign mult_rst_n = rst_n & (state_q != S_CLEAR);
   assign mult_op    = in_data;
   assign state_dbg  = state_q;

   hmul_seq_datapath #(
      .DIMENSION        (DIMENSION),
      .DIM_WIDTH        (DIM_WIDTH),
      .CIPHERTEXT_WIDTH (CIPHERTEXT_WIDTH),
      .PARALLEL         (PARALLEL)
   ) u_datapath (
      .clk               (clk),
      .rst_n             (mult_rst_n),
      .row               (mult_row),
      .ciphertext_select (mult_sel),
      .en                (mult_en),
      .op                (mult_op),
      .result_partial    (out_data)
   );

`ifdef HMUL_SEQ_PERF_EN
   logic [15:0] perf_q, perf_d;

   // Counts CLEAR through DRAIN, so a stall-free run reports the work cycles only.
   always_comb begin
      perf_d = perf_q;
      if (state_q == S_IDLE && start)
         perf_d = '0;
      else if (state_q != S_IDLE && state_q != S_DONE && perf_q != 16'hFFFF)
         perf_d = perf_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`else
   // No cycle counter in this build.
`endif

   a_no_dual_stream: assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && out_valid));
   a_en_in_load:     assert property (@(posedge clk) disable iff (!rst_n) mult_en |-> in_ready);
   a_done_to_idle:   assert property (@(posedge clk) disable iff (!rst_n) (state_q == S_DONE) |=> (state_q == S_IDLE));
endmodule

// File: tb/tb_hmul_sequencer.sv
// Directed bench for hmul_sequencer with D=1, P=1, 10-bit coefficients.
module tb_hmul_sequencer;
  localparam int D  = 1;
  localparam int DW = 1;
  localparam int W  = 10;
  localparam int P  = 1;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          busy, done, in_ready, out_valid, mult_rst_n, mult_sel, mult_en;
  logic [W-1:0]  out_data, mult_op;
  logic [DW:0]   out_index, mult_row;
  logic [2:0]    state_dbg;
`ifdef HMUL_SEQ_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  logic [W-1:0] exp_q[$];

  hmul_sequencer #(.DIMENSION(D), .DIM_WIDTH(DW), .CIPHERTEXT_WIDTH(W), .PARALLEL(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .mult_rst_n(mult_rst_n), .mult_op(mult_op), .mult_row(mult_row), .mult_sel(mult_sel),
    .mult_en(mult_en), .state_dbg(state_dbg)
`ifdef HMUL_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic start_op();
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv_beat(output logic [W-1:0] d, output logic [DW:0] ix);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL recv_timeout out_valid=%0b required 1", out_valid);
    end
    d  = out_data;
    ix = out_index;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_mult(input logic [W-1:0] a0, a1, b0, b1,
                         output logic [3*W-1:0] r, output logic [3*(DW+1)-1:0] ix);
    logic [W-1:0] d;
    logic [DW:0]  i;
    start_op();
    send_beat(a0); send_beat(a1); send_beat(b0); send_beat(b1);
    for (int k = 0; k < 3; k++) begin
      recv_beat(d, i);
      r[k*W +: W]          = d;
      ix[k*(DW+1) +: DW+1] = i;
    end
  endtask

  // scoreboard: pop expected product coefficients against received ones
  task automatic check_products(input string name, input logic [3*W-1:0] r,
                                input logic [3*(DW+1)-1:0] ix);
    logic [W-1:0] e;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (r[k*W +: W] !== e) begin
        errors++;
        $display("FAIL %s coef%0d got %0d want %0d", name, k, r[k*W +: W], e);
      end
      checks++;
      if (ix[k*(DW+1) +: DW+1] !== (DW+1)'(k)) begin
        errors++;
        $display("FAIL %s index%0d got %0d want %0d", name, k, ix[k*(DW+1) +: DW+1], k);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    logic [10:0] got, want;
    got  = {busy, done, in_ready, out_valid, out_index, mult_row, mult_sel, mult_en, mult_rst_n};
    want = 11'b0;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s outputs got %b want %b", name, got, want);
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL %s state got %0d want 0", name, state_dbg);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
`ifdef HMUL_SEQ_PERF_EN
    checks++;
    if (perf_cycles !== 16'd0) begin errors++; $display("FAIL reset_perf got %0d want 0", perf_cycles); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3*W-1:0] r;
    logic [3*(DW+1)-1:0] ix;
    exp_q.push_back(10'd21); exp_q.push_back(10'd41); exp_q.push_back(10'd10);
    do_mult(10'd3, 10'd5, 10'd7, 10'd2, r, ix);
    check_products("basic", r, ix);
    checks++;
    if (done !== 1'b1 || (cyc - t0) !== 9) begin
      errors++;
      $display("FAIL basic_latency done=%0b edges=%0d want done=1 edges=9", done, cyc - t0);
    end
`ifdef HMUL_SEQ_PERF_EN
    checks++;
    if (perf_cycles !== 16'd8) begin errors++; $display("FAIL basic_perf got %0d want 8", perf_cycles); end
`endif
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse done=%0b busy=%0b want 0 0", done, busy);
    end
`ifdef HMUL_SEQ_PERF_EN
    tick();
    checks++;
    if (perf_cycles !== 16'd8) begin errors++; $display("FAIL perf_hold got %0d want 8", perf_cycles); end
`endif
  endtask

  task automatic test_wrap();
    logic [3*W-1:0] r;
    logic [3*(DW+1)-1:0] ix;
    exp_q.push_back(10'd976); exp_q.push_back(10'd976); exp_q.push_back(10'd0);
    do_mult(10'd1000, 10'd1000, 10'd2, 10'd0, r, ix);
    check_products("wrap", r, ix);
  endtask

  task automatic test_back_to_back();
    logic [3*W-1:0] r;
    logic [3*(DW+1)-1:0] ix;
    exp_q.push_back(10'd21); exp_q.push_back(10'd41); exp_q.push_back(10'd10);
    do_mult(10'd3, 10'd5, 10'd7, 10'd2, r, ix);
    check_products("b2b_first", r, ix);
    exp_q.push_back(10'd1); exp_q.push_back(10'd2); exp_q.push_back(10'd1);
    do_mult(10'd1, 10'd1, 10'd1, 10'd1, r, ix);
    check_products("b2b_second", r, ix);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ops[4];
    logic [W-1:0] d;
    logic [DW:0]  i;
    logic [2:0]   st;
    logic [DW:0]  rw;
    ops = '{10'd3, 10'd5, 10'd7, 10'd2};
    start_op();
    checks++;
    if (mult_rst_n !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_state mult_rst_n=%0b busy=%0b in_ready=%0b want 0 1 0", mult_rst_n, busy, in_ready);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b0;
      st = state_dbg;
      rw = mult_row;
      tick();
      checks++;
      if (state_dbg !== st || mult_row !== rw || mult_en !== 1'b0) begin
        errors++;
        $display("FAIL bubble%0d state=%0d row=%0d en=%0b want %0d %0d 0", k, state_dbg, mult_row, mult_en, st, rw);
      end
      checks++;
      if (mult_sel !== (k >= 2) || mult_row !== (DW+1)'(k % 2)) begin
        errors++;
        $display("FAIL load_ctrl%0d sel=%0b row=%0d want %0b %0d", k, mult_sel, mult_row, (k >= 2), k % 2);
      end
      send_beat(ops[k]);
    end
    recv_beat(d, i);
    checks++;
    if (d !== 10'd21 || i !== 2'd0) begin errors++; $display("FAIL bp_beat0 got %0d@%0d want 21@0", d, i); end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (out_valid !== 1'b1 || out_index !== 2'd1 || out_data !== 10'd41 || mult_row !== 2'd2) begin
        errors++;
        $display("FAIL bp_stall%0d valid=%0b idx=%0d data=%0d row=%0d want 1 1 41 2", s, out_valid, out_index, out_data, mult_row);
      end
      tick();
    end
    recv_beat(d, i);
    checks++;
    if (d !== 10'd41 || i !== 2'd1) begin errors++; $display("FAIL bp_beat1 got %0d@%0d want 41@1", d, i); end
    recv_beat(d, i);
    checks++;
    if (d !== 10'd10 || i !== 2'd2) begin errors++; $display("FAIL bp_beat2 got %0d@%0d want 10@2", d, i); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %0b want 1", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3*W-1:0] r;
    logic [3*(DW+1)-1:0] ix;
    start_op();
    send_beat(10'd3); send_beat(10'd5); send_beat(10'd7);
    checks++;
    if (state_dbg !== 3'd3) begin errors++; $display("FAIL mid_in_load_b state got %0d want 3", state_dbg); end
    rst_n = 1'b0;
    tick();
    check_idle_outputs("reset_mid");
    rst_n = 1'b1;
    tick();
    exp_q.push_back(10'd21); exp_q.push_back(10'd41); exp_q.push_back(10'd10);
    do_mult(10'd3, 10'd5, 10'd7, 10'd2, r, ix);
    check_products("after_reset", r, ix);
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] d;
    logic [DW:0]  i;
    start_op();
    send_beat(10'd3); send_beat(10'd5); send_beat(10'd7); send_beat(10'd2);
    recv_beat(d, i);
    start = 1'b1;
    recv_beat(d, i);
    start = 1'b0;
    recv_beat(d, i);
    checks++;
    if (done !== 1'b1 || d !== 10'd10) begin errors++; $display("FAIL ign_done done=%0b last=%0d want 1 10", done, d); end
    tick();
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (busy !== 1'b0 || state_dbg !== 3'd0) begin
        errors++;
        $display("FAIL ign_idle%0d busy=%0b state=%0d want 0 0", s, busy, state_dbg);
      end
      tick();
    end
  endtask

  task automatic test_idle_inputs();
    in_valid = 1'b1;
    in_data  = 10'h155;
    #1;
    checks++;
    if (in_ready !== 1'b0 || mult_en !== 1'b0 || mult_op !== 10'h155) begin
      errors++;
      $display("FAIL idle_input ready=%0b en=%0b op=%0h want 0 0 155", in_ready, mult_en, mult_op);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || mult_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold busy=%0b mult_rst_n=%0b want 0 1", busy, mult_rst_n);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_ignored_start();
    test_idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
